// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Lets two requesters share one external combinational ALU. Port 0 is the
//   main datapath, port 1 an auxiliary unit. Each op is a valid/ready
//   request. The op is executed in the cycle it is granted, and its result
//   is captured into a per-port response register. That register is held
//   until the requester accepts it. Only one op is in flight at a time.
//   Per-port grant counters support performance checks.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN - when defined, port 0 always wins a tie (port 1
//                           can starve); otherwise ties go round-robin.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   reqN_valid/ready    request handshake for port N (ready is combinational)
//   reqN_a/b/op         port N operands and ALU opcode
//   rspN_valid/ready    response handshake for port N (valid is registered)
//   rspN_result/zero    port N registered ALU result and Zero flag
//   alu_a/b/op          drive the shared ALU (granted operands, else 0)
//   alu_result/zero     return path from the shared ALU
//   grant_cnt0/1        accepted-request counters, wrap modulo 2^CNT_W
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    typedef enum logic [1:0] {IDLE, RESP0, RESP1} state_t;

    state_t            state_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              last_grant_q;
`endif
    logic              rsp0_valid_q, rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_result_q, rsp1_result_q;
    logic              rsp0_zero_q, rsp1_zero_q;
    logic [CNT_W-1:0]  grant_cnt0_q, grant_cnt1_q;

    logic              grant0, grant1;

    // Grant is only possible in IDLE and out of reset, so a request is
    // never seen as accepted on an edge that reset is going to discard.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset && (state_q == IDLE)) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
`else
            if (req0_valid && req1_valid) begin
                // Tie: give it to the port that did not win last time.
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // The ALU sees the granted operands in the grant cycle and zeros otherwise.
    assign alu_a  = grant0 ? req0_a  : (grant1 ? req1_a  : '0);
    assign alu_b  = grant0 ? req0_b  : (grant1 ? req1_b  : '0);
    assign alu_op = grant0 ? req0_op : (grant1 ? req1_op : '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= 1'b1;
`endif
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_zero_q   <= 1'b0;
            grant_cnt0_q  <= '0;
            grant_cnt1_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0) begin
                        rsp0_result_q <= alu_result;
                        rsp0_zero_q   <= alu_zero;
                        rsp0_valid_q  <= 1'b1;
                        grant_cnt0_q  <= grant_cnt0_q + CNT_W'(1);
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant_q  <= 1'b0;
`endif
                        state_q       <= RESP0;
                    end else if (grant1) begin
                        rsp1_result_q <= alu_result;
                        rsp1_zero_q   <= alu_zero;
                        rsp1_valid_q  <= 1'b1;
                        grant_cnt1_q  <= grant_cnt1_q + CNT_W'(1);
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant_q  <= 1'b1;
`endif
                        state_q       <= RESP1;
                    end
                end
                RESP0: begin
                    if (rsp0_ready) begin
                        rsp0_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                RESP1: begin
                    if (rsp1_ready) begin
                        rsp1_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_zero   = rsp1_zero_q;
    assign grant_cnt0  = grant_cnt0_q;
    assign grant_cnt1  = grant_cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter. A behavioural model tracks, per
// cycle, which port owns the ALU, which responses are pending, and the grant
// counts. Directed scenarios are followed by randomized traffic. The counter
// wrap scenario uses a narrower CNT_W so that the wrap is reached quickly.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int CNT_W  = 10;
    localparam int CNT_MOD = 1 << CNT_W;

    logic              clk;
    logic              reset;
    logic              v0, v1, rr0, rr1;
    logic [DATA_W-1:0] a0, b0, a1, b1;
    logic [OP_W-1:0]   op0, op1;
    logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_result, rsp1_result;
    logic              rsp0_zero, rsp1_zero;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [OP_W-1:0]   alu_op;
    logic              alu_zero;
    logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(req0_ready), .req0_a(a0), .req0_b(b0), .req0_op(op0),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rr0), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(v1), .req1_ready(req1_ready), .req1_a(a1), .req1_b(b1), .req1_op(op1),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rr1), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU behaviour: AND, OR, ADD, SUB; anything else yields 0.
    // Zero always reports A==B.
    function automatic logic [DATA_W:0] alu_ref(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [OP_W-1:0] op);
        logic [DATA_W-1:0] r;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a - b;
            default: r = '0;
        endcase
        return {(a == b), r};
    endfunction

    always_comb {alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_op);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state.
    int                m_busy;       // -1 idle, else port whose response is pending
    int                m_last;       // port granted most recently
    int                m_cnt[2];
    logic              m_vld[2];
    logic [DATA_W-1:0] m_res[2];
    logic              m_zero[2];
    int                last_g;       // port accepted in the last step, -1 none

    function automatic void model_reset();
        m_busy = -1;
        m_last = 1;
        for (int p = 0; p < 2; p++) begin
            m_cnt[p] = 0; m_vld[p] = 1'b0; m_res[p] = '0; m_zero[p] = 1'b0;
        end
    endfunction

    function automatic int pick();
        if (!reset || m_busy >= 0) return -1;
        if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - m_last;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // One clock cycle with the current inputs: check the same-cycle outputs,
    // advance the model across the edge, then check registered outputs.
    task automatic step();
        int g;
        logic [DATA_W:0] e;
        logic [DATA_W-1:0] ea, eb;
        logic [OP_W-1:0] eop;
        #2;
        g = pick();
        ea = '0; eb = '0; eop = '0;
        if (g == 0) begin ea = a0; eb = b0; eop = op0; end
        if (g == 1) begin ea = a1; eb = b1; eop = op1; end
        check("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_op", {28'd0, alu_op}, {28'd0, eop});
        @(posedge clk);
        #1;
        if (!reset) begin
            model_reset();
            last_g = -1;
        end else if (g >= 0) begin
            e = alu_ref(ea, eb, eop);
            m_res[g] = e[DATA_W-1:0];
            m_zero[g] = e[DATA_W];
            m_vld[g] = 1'b1;
            m_cnt[g] = (m_cnt[g] + 1) % CNT_MOD;
            m_last = g;
            m_busy = g;
            last_g = g;
        end else begin
            last_g = -1;
            if (m_busy >= 0 && (m_busy == 0 ? rr0 : rr1)) begin
                $display("txn port%0d result=%h zero=%0d cnt=%0d",
                         m_busy, m_res[m_busy], m_zero[m_busy], m_cnt[m_busy]);
                m_vld[m_busy] = 1'b0;
                m_busy = -1;
            end
        end
        check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_vld[0]});
        check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_vld[1]});
        if (m_vld[0]) begin
            check("rsp0_result", rsp0_result, m_res[0]);
            check("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, m_zero[0]});
        end
        if (m_vld[1]) begin
            check("rsp1_result", rsp1_result, m_res[1]);
            check("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, m_zero[1]});
        end
        check("grant_cnt0", {22'd0, grant_cnt0}, DATA_W'(m_cnt[0]));
        check("grant_cnt1", {22'd0, grant_cnt1}, DATA_W'(m_cnt[1]));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        model_reset();
        last_g = -1;

        // Reset, then a continuous both-valid tie (first tie goes to port 0).
        do_reset();
        check("rst_rsp0_result", rsp0_result, '0);
        v0 = 1; a0 = 7; b0 = 7; op0 = 4'b0011;
        v1 = 1; a1 = 32'hF0; b1 = 32'h0F; op1 = 4'b0001;
        rr0 = 1; rr1 = 1;
        #2;
        check("tie_first_port0", {31'd0, req0_ready}, 32'd1);
        for (int i = 0; i < 8; i++) step();
`ifndef ALU_ARB_FIXED_PRIO_EN
        check("alt_port1_result", rsp1_result, 32'hFF);
`endif
        check("alt_port0_result", rsp0_result, 32'd0);

        // Single op on port 0: 5 + 3.
        do_reset();
        v1 = 0; v0 = 1; a0 = 5; b0 = 3; op0 = 4'b0010; rr0 = 1;
        step();
        check("add_result", rsp0_result, 32'd8);
        check("add_zero", {31'd0, rsp0_zero}, 32'd0);
        v0 = 0;
        step();
        step();
        check("add_cnt0", {22'd0, grant_cnt0}, 32'd1);

        // Port 1 response stalled for 5 cycles while port 0 waits.
        v1 = 1; a1 = 32'h1234; b1 = 32'h1; op1 = 4'b0011; rr1 = 0;
        step();
        v1 = 0; v0 = 1; a0 = 9; b0 = 9; op0 = 4'b0000;
        for (int i = 0; i < 5; i++) step();
        check("stall_rsp1_hold", rsp1_result, 32'h1233);
        rr1 = 1;
        step();
        step();
        check("stall_then_grant0", {31'd0, rsp0_valid}, 32'd1);
        v0 = 0;
        step();

        // Reset while a port 0 response is pending.
        v0 = 1; a0 = 32'hDEAD; b0 = 32'h1; op0 = 4'b0010; rr0 = 0;
        step();
        v0 = 0;
        reset = 1'b0;
        step();
        check("midrst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("midrst_rsp0_result", rsp0_result, 32'd0);
        check("midrst_cnt0", {22'd0, grant_cnt0}, 32'd0);
        reset = 1'b1;

        // Randomized traffic; requests are held until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!v0 || last_g == 0) begin
                v0 = ($urandom_range(0, 2) != 0);
                a0 = $urandom;
                b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
                op0 = OP_W'($urandom_range(0, 15));
            end
            if (!v1 || last_g == 1) begin
                v1 = ($urandom_range(0, 2) != 0);
                a1 = $urandom;
                b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
                op1 = OP_W'($urandom_range(0, 15));
            end
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            step();
        end

        // Grant counter wrap on port 0, then an unsupported opcode on port 1.
        v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
        do_reset();
        v0 = 1;
        for (int i = 0; i < CNT_MOD; i++) begin
            a0 = $urandom; b0 = $urandom; op0 = OP_W'($urandom_range(0, 3));
            step();
            step();
            if (i == CNT_MOD - 2)
                check("cnt0_at_max", {22'd0, grant_cnt0}, DATA_W'(CNT_MOD - 1));
        end
        check("cnt0_wrapped", {22'd0, grant_cnt0}, 32'd0);
        v0 = 0;
        v1 = 1; a1 = 1; b1 = 1; op1 = 4'b0111;
        step();
        check("badop_result", rsp1_result, 32'd0);
        check("badop_zero", {31'd0, rsp1_zero}, 32'd1);
        v1 = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
